fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/chocolate_pkg.sv | 17 +
 rtl/fetch_sequencer_pc_unit.sv | 36 +++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chocolate_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, opcode
// constants recognised by the external decoder, and the default address width.
package chocolate_pkg;

  localparam int PC_W_DEFAULT = 8;

  localparam logic [7:0] LOAD_NEXT_OP = 8'h80;
  localparam logic [1:0] JUMP_PREFIX  = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_ISSUE     = 2'd1,
    S_FETCH_IMM = 2'd2,
    S_IMM_ISSUE = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_sequencer_pc_unit.sv
// Program counter register with increment / load mux.
// A load takes priority over an increment; increments wrap modulo 2^PC_W.
module pc_unit #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches opcode bytes (and the immediate byte
// that follows a load-next opcode) and presents them to an external decoder.
module fetch_sequencer
  import chocolate_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic [7:0]      instr,
  output logic            force_nop,
  input  logic            is_jump,
  input  logic            is_load_next,
  input  logic            jump_taken,
  input  logic [PC_W-1:0] jump_target,
  input  logic            stall,
  output logic [7:0]      imm_data,
  output logic            imm_valid,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      state_dbg
);

  // Handshakes: imem_req stays high with imem_addr stable until a cycle with
  // imem_ack=1 completes the read (imem_ack with imem_req=0 is ignored).
  // stall is the inverse of ready for ISSUE / IMM_ISSUE: while it is high the
  // presented byte and all state are held, and it overrides every other input.

  state_e     state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] imm_q, imm_d;
  logic       pc_inc;
  logic       pc_load;

  pc_unit #(.PC_W(PC_W)) u_pc_unit (
    .clk    (clk),
    .rst    (rst),
    .inc    (pc_inc),
    .load   (pc_load),
    .target (jump_target),
    .pc     (pc)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    imem_req  = 1'b0;
    force_nop = 1'b1;
    imm_valid = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          pc_inc  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        force_nop = 1'b0;
        if (!stall) begin
          if (is_load_next) begin
            state_d = S_FETCH_IMM;
          end else begin
            pc_load = is_jump & jump_taken;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH_IMM: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          imm_d   = imem_rdata;
          pc_inc  = 1'b1;
          state_d = S_IMM_ISSUE;
        end
      end
      S_IMM_ISSUE: begin
        imm_valid = 1'b1;
        if (!stall) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      instr_q <= 8'h00;
      imm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
    end
  end

  assign imem_addr = pc;
  assign instr     = instr_q;
  assign imm_data  = imm_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_sequencer;
  import chocolate_pkg::*;

  localparam int PC_W = 8;

  localparam int M_FETCH     = 0;
  localparam int M_ISSUE     = 1;
  localparam int M_FETCH_IMM = 2;
  localparam int M_IMM_ISSUE = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [7:0]      imem_rdata = 8'h00;
  logic [7:0]      instr;
  logic            force_nop;
  logic            is_jump;
  logic            is_load_next;
  logic            jump_taken = 1'b0;
  logic [PC_W-1:0] jump_target = '0;
  logic            stall = 1'b0;
  logic [7:0]      imm_data;
  logic            imm_valid;
  logic [PC_W-1:0] pc;
  logic [1:0]      state_dbg;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(PC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .force_nop    (force_nop),
    .is_jump      (is_jump),
    .is_load_next (is_load_next),
    .jump_taken   (jump_taken),
    .jump_target  (jump_target),
    .stall        (stall),
    .imm_data     (imm_data),
    .imm_valid    (imm_valid),
    .pc           (pc),
    .state_dbg    (state_dbg)
  );

  // External decoder as it would sit in the parent.
  assign is_jump      = (instr[7:6] == JUMP_PREFIX);
  assign is_load_next = (instr == LOAD_NEXT_OP);

  // Reference model and scoreboard
  logic [7:0] mem [256];
  int         m_mode;
  logic [7:0] m_pc;
  logic [7:0] m_instr;
  logic [7:0] m_imm;
  logic [7:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk1("imem_req", imem_req, (m_mode == M_FETCH) || (m_mode == M_FETCH_IMM));
    if (m_mode == M_FETCH || m_mode == M_FETCH_IMM)
      chk8("imem_addr", imem_addr, m_pc);
    chk8("pc", pc, m_pc);
    chk8("instr", instr, m_instr);
    chk1("force_nop", force_nop, m_mode != M_ISSUE);
    chk1("imm_valid", imm_valid, m_mode == M_IMM_ISSUE);
    if (m_mode == M_IMM_ISSUE)
      chk8("imm_data", imm_data, m_imm);
  endtask

  // Reset asserted now (any phase of the cycle); released at the next negedge.
  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    stall = 1'b0;
    jump_taken = 1'b0;
    m_mode  = M_FETCH;
    m_pc    = 8'h00;
    m_instr = 8'h00;
    m_imm   = 8'h00;
    exp_q.delete();
    #1;
    check_outputs();
    chk8("rst_imm_data", imm_data, 8'h00);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs at the negedge, check, advance the model.
  task automatic cyc(input logic ack, input logic stl, input logic jt, input logic [7:0] tgt);
    logic m_jump;
    logic m_ld;
    imem_ack    = ack;
    stall       = stl;
    jump_taken  = jt;
    jump_target = tgt;
    imem_rdata  = mem[imem_addr];
    #1;
    check_outputs();
    m_jump = (m_instr[7:6] == 2'b11);
    m_ld   = (m_instr == 8'h80);
    case (m_mode)
      M_FETCH: if (ack) begin
        m_instr = mem[m_pc];
        exp_q.push_back(mem[m_pc]);
        m_pc   = m_pc + 8'd1;
        m_mode = M_ISSUE;
      end
      M_ISSUE: if (!stl) begin
        if (exp_q.size() > 0) chk8("issued_instr", instr, exp_q.pop_front());
        if (m_ld) begin
          m_mode = M_FETCH_IMM;
        end else begin
          if (m_jump && jt) m_pc = tgt;
          m_mode = M_FETCH;
        end
      end
      M_FETCH_IMM: if (ack) begin
        m_imm  = mem[m_pc];
        m_pc   = m_pc + 8'd1;
        m_mode = M_IMM_ISSUE;
      end
      default: if (!stl) m_mode = M_FETCH;
    endcase
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));

    // Two plain instructions from zero-wait memory
    mem[0] = 8'h01; mem[1] = 8'h02;
    do_reset();
    cyc(1, 0, 0, 8'h00);
    chk8("t1_first_instr", instr, 8'h01);
    chk1("t1_first_issue", force_nop, 1'b0);
    cyc(0, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    chk8("t1_second_instr", instr, 8'h02);
    cyc(0, 0, 0, 8'h00);
    chk8("t1_pc_after", pc, 8'h02);

    // Load-next pair
    mem[0] = 8'h80; mem[1] = 8'h5A;
    do_reset();
    cyc(1, 0, 0, 8'h00);
    chk8("t2_opcode", instr, 8'h80);
    cyc(0, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    chk1("t2_imm_valid", imm_valid, 1'b1);
    chk8("t2_imm_data", imm_data, 8'h5A);
    chk1("t2_force_nop", force_nop, 1'b1);
    cyc(0, 0, 0, 8'h00);
    chk1("t2_imm_valid_drop", imm_valid, 1'b0);
    chk8("t2_pc_after", pc, 8'h02);

    // Jump at address 3, taken then not taken
    for (int t = 0; t < 2; t++) begin
      mem[0] = 8'h01; mem[1] = 8'h01; mem[2] = 8'h01; mem[3] = 8'hC5;
      do_reset();
      for (int k = 0; k < 4; k++) begin
        cyc(1, 0, 0, 8'h00);
        cyc(0, 0, t == 0, 8'h40);
      end
      chk8("t3_next_addr", imem_addr, (t == 0) ? 8'h40 : 8'h04);
    end

    // Stall for 3 cycles while a taken jump is presented
    mem[0] = 8'hC0; mem[8'h40] = 8'h01;
    do_reset();
    cyc(1, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 8'h40);
      chk8("t4_held_instr", instr, 8'hC0);
      chk1("t4_held_issue", force_nop, 1'b0);
    end
    cyc(0, 0, 1, 8'h40);
    chk8("t4_jump_addr", imem_addr, 8'h40);
    cyc(1, 0, 0, 8'h00);
    chk8("t4_pc_once", pc, 8'h41);

    // Wrap from 0xFF with a 3-cycle delayed ack
    mem[0] = 8'hC0; mem[8'hFF] = 8'h01;
    do_reset();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 8'h00);
      chk8("t5_addr_stable", imem_addr, 8'hFF);
      chk1("t5_req_stable", imem_req, 1'b1);
    end
    cyc(1, 0, 0, 8'h00);
    chk8("t5_pc_wrap", pc, 8'h00);

    // Reset in the middle of an immediate fetch, then an ack after release
    mem[0] = 8'h80; mem[1] = 8'h77;
    do_reset();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    #2;
    do_reset();
    chk1("t6_imm_valid", imm_valid, 1'b0);
    cyc(1, 0, 0, 8'h00);
    chk8("t6_first_issue", instr, 8'h80);
    chk8("t6_pc", pc, 8'h01);

    // Randomized traffic, including acks while no request is pending
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
